// File: rtl/sa_alloc_5p_pkg.sv
// Shared constants, direction codes and decode helper for the 5-port switch allocator.
package sa_alloc_5p_pkg;

  localparam int NUM_IN   = 5;
  localparam int DATASIZE = 40;
  localparam int DEPTH    = 8;
  localparam int WIDTH    = 3;
  localparam int PTR_W    = 3;

  localparam int PORT_L = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_N = 3;
  localparam int PORT_W = 4;

  localparam logic [3:0] DIR_L    = 4'b0000;
  localparam logic [3:0] DIR_S    = 4'b0001;
  localparam logic [3:0] DIR_E    = 4'b0010;
  localparam logic [3:0] DIR_N    = 4'b0100;
  localparam logic [3:0] DIR_W    = 4'b1000;
  localparam logic [3:0] DIR_NONE = 4'b1111;

  typedef struct packed {
    logic             valid;
    logic             illegal;
    logic [PTR_W-1:0] idx;
  } dir_dec_t;

  function automatic dir_dec_t dir_decode(input logic [3:0] dir);
    dir_dec_t d;
    d = '{valid: 1'b1, illegal: 1'b0, idx: '0};
    case (dir)
      DIR_L:    d.idx = PTR_W'(PORT_L);
      DIR_S:    d.idx = PTR_W'(PORT_S);
      DIR_E:    d.idx = PTR_W'(PORT_E);
      DIR_N:    d.idx = PTR_W'(PORT_N);
      DIR_W:    d.idx = PTR_W'(PORT_W);
      DIR_NONE: d.valid = 1'b0;
      default: begin
        d.valid   = 1'b0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sa_alloc_5p_if.sv
// Request/output bundle between the route-compute stages, the allocator and the link side.
interface sa_alloc_5p_if;
  import sa_alloc_5p_pkg::*;

  logic [NUM_IN*DATASIZE-1:0]  req_data_in;
  logic [NUM_IN*4-1:0]         req_dir_in;
  logic [NUM_IN-1:0]           rc_ready_out;
  logic [NUM_IN*DATASIZE-1:0]  out_data;
  logic [NUM_IN-1:0]           out_valid;
  logic [NUM_IN-1:0]           credit_in;
  logic [NUM_IN*(WIDTH+1)-1:0] occupancy_out;
  logic                        err_credit;
  logic                        err_dir;

  modport master (
    output req_data_in, req_dir_in, credit_in,
    input  rc_ready_out, out_data, out_valid, occupancy_out, err_credit, err_dir
  );

  modport slave (
    input  req_data_in, req_dir_in, credit_in,
    output rc_ready_out, out_data, out_valid, occupancy_out, err_credit, err_dir
  );

endinterface

// File: rtl/sa_alloc_5p_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr wins, wrapping N-1 -> 0.
module sa_alloc_5p_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin : search
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sa_alloc_5p.sv
// 5-port switch allocator: per-output round-robin arbitration gated by downstream credits,
// registered output flits, and per-input ready back to the route-compute stage.
module sa_alloc_5p
  import sa_alloc_5p_pkg::*;
(
  input logic          sa_clk,
  input logic          rst_n,
  sa_alloc_5p_if.slave bus
);

  localparam logic [WIDTH:0] CREDIT_MAX = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0] CREDIT_ONE = (WIDTH+1)'(1);

  logic [NUM_IN-1:0]   req_mat  [NUM_IN];
  logic [NUM_IN-1:0]   elig     [NUM_IN];
  logic [NUM_IN-1:0]   gnt_mat  [NUM_IN];
  logic [PTR_W-1:0]    ptr_q    [NUM_IN];
  logic [PTR_W-1:0]    win_idx  [NUM_IN];
  logic [DATASIZE-1:0] win_data [NUM_IN];
  logic [WIDTH:0]      credit_q [NUM_IN];
  logic [WIDTH:0]      credit_d [NUM_IN];
  logic [DATASIZE-1:0] data_q   [NUM_IN];
  logic [WIDTH:0]      occ_q    [NUM_IN];
  logic [NUM_IN-1:0]   dir_none, dir_bad, gnt_in, gnt_out, credit_ovf, valid_q;
  logic                err_credit_q, err_dir_q;

  // req_mat[o][i]: input i wants output o this cycle.
  always_comb begin : decode
    dir_dec_t dec;
    dec      = '0;
    dir_none = '0;
    dir_bad  = '0;
    for (int o = 0; o < NUM_IN; o++) req_mat[o] = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dec         = dir_decode(bus.req_dir_in[i*4 +: 4]);
      dir_none[i] = ~dec.valid;
      dir_bad[i]  = dec.illegal;
      for (int o = 0; o < NUM_IN; o++)
        if (dec.valid && dec.idx == PTR_W'(o)) req_mat[o][i] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_IN; o++)
      elig[o] = (credit_q[o] != '0) ? req_mat[o] : '0;
  end

  for (genvar o = 0; o < NUM_IN; o++) begin : g_arb
    sa_alloc_5p_rr_arbiter #(.N(NUM_IN), .PW(PTR_W)) u_arb (
      .req   (elig[o]),
      .ptr   (ptr_q[o]),
      .grant (gnt_mat[o])
    );
  end

  always_comb begin : select
    gnt_in     = '0;
    gnt_out    = '0;
    credit_ovf = '0;
    for (int o = 0; o < NUM_IN; o++) begin
      win_idx[o]  = '0;
      win_data[o] = '0;
      credit_d[o] = credit_q[o];
      gnt_out[o]  = |gnt_mat[o];
      gnt_in      = gnt_in | gnt_mat[o];
      for (int i = 0; i < NUM_IN; i++) begin
        if (gnt_mat[o][i]) begin
          win_idx[o]  = PTR_W'(i);
          win_data[o] = bus.req_data_in[i*DATASIZE +: DATASIZE];
        end
      end
      // A grant and a returned credit in the same cycle cancel out.
      if (gnt_out[o] && !bus.credit_in[o]) begin
        credit_d[o] = credit_q[o] - CREDIT_ONE;
      end else if (!gnt_out[o] && bus.credit_in[o]) begin
        if (credit_q[o] == CREDIT_MAX) credit_ovf[o] = 1'b1;
        else                           credit_d[o]   = credit_q[o] + CREDIT_ONE;
      end
    end
  end

  // Empty or illegal RC slots always drain; blocked requests hold.
  assign bus.rc_ready_out = gnt_in | dir_none;

  always_ff @(posedge sa_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_IN; o++) begin
        ptr_q[o]    <= '0;
        credit_q[o] <= CREDIT_MAX;
        data_q[o]   <= '0;
        occ_q[o]    <= '0;
      end
      valid_q      <= '0;
      err_credit_q <= 1'b0;
      err_dir_q    <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_IN; o++) begin
        valid_q[o] <= gnt_out[o];
        if (gnt_out[o]) begin
          data_q[o] <= win_data[o];
          ptr_q[o]  <= (win_idx[o] == PTR_W'(NUM_IN-1)) ? '0 : win_idx[o] + PTR_W'(1);
        end
        credit_q[o] <= credit_d[o];
        occ_q[o]    <= CREDIT_MAX - credit_d[o];
      end
      err_credit_q <= err_credit_q | (|credit_ovf);
      err_dir_q    <= err_dir_q | (|dir_bad);
    end
  end

  for (genvar o = 0; o < NUM_IN; o++) begin : g_out
    assign bus.out_data[o*DATASIZE +: DATASIZE]        = data_q[o];
    assign bus.occupancy_out[o*(WIDTH+1) +: WIDTH+1]   = occ_q[o];
  end

  assign bus.out_valid  = valid_q;
  assign bus.err_credit = err_credit_q;
  assign bus.err_dir    = err_dir_q;

endmodule

// File: tb/tb_sa_alloc_5p.sv
// Bench for sa_alloc_5p: constant vector table, directed corner sequences, and a random
// run compared against a behavioural allocator model.
module tb_sa_alloc_5p;
  import sa_alloc_5p_pkg::*;

  logic sa_clk = 1'b0;
  logic rst_n;
  always #5 sa_clk = ~sa_clk;

  sa_alloc_5p_if sa_bus ();
  sa_alloc_5p dut (.sa_clk(sa_clk), .rst_n(rst_n), .bus(sa_bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_credit [5];
  int         m_ptr    [5];
  int         m_win    [5];
  logic [39:0] m_odata [5];
  logic [4:0] m_ovalid;
  logic [4:0] m_ready;
  logic       m_err_c, m_err_d;
  logic [4:0] act_ready;

  function automatic int dec(input logic [3:0] d);
    case (d)
      4'b0000: return 0;
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 3;
      4'b1000: return 4;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_credit[o] = 8;
      m_ptr[o]    = 0;
      m_odata[o]  = '0;
    end
    m_ovalid = '0;
    m_err_c  = 1'b0;
    m_err_d  = 1'b0;
  endtask

  task automatic model_eval();
    for (int o = 0; o < 5; o++) begin
      m_win[o] = -1;
      if (m_credit[o] > 0)
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (m_ptr[o] + k) % 5;
          if (m_win[o] < 0 && dec(sa_bus.req_dir_in[i*4 +: 4]) == o) m_win[o] = i;
        end
    end
    for (int i = 0; i < 5; i++) begin
      m_ready[i] = dec(sa_bus.req_dir_in[i*4 +: 4]) < 0;
      for (int o = 0; o < 5; o++) if (m_win[o] == i) m_ready[i] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 5; i++)
      if (dec(sa_bus.req_dir_in[i*4 +: 4]) == -2) m_err_d = 1'b1;
    for (int o = 0; o < 5; o++) begin
      bit g, c;
      g = m_win[o] >= 0;
      c = sa_bus.credit_in[o];
      m_ovalid[o] = g;
      if (g) begin
        m_odata[o] = sa_bus.req_data_in[m_win[o]*40 +: 40];
        m_ptr[o]   = (m_win[o] + 1) % 5;
      end
      if (g && !c) m_credit[o]--;
      else if (!g && c) begin
        if (m_credit[o] == 8) m_err_c = 1'b1;
        else                  m_credit[o]++;
      end
    end
  endtask

  task automatic check_regs();
    logic [199:0] exp_data;
    logic [19:0]  exp_occ;
    for (int o = 0; o < 5; o++) begin
      exp_data[o*40 +: 40] = m_odata[o];
      exp_occ[o*4 +: 4]    = 4'(8 - m_credit[o]);
    end
    chk("out_valid", sa_bus.out_valid, m_ovalid);
    chk("out_data", sa_bus.out_data, exp_data);
    chk("occupancy", sa_bus.occupancy_out, exp_occ);
    chk("err_credit", sa_bus.err_credit, m_err_c);
    chk("err_dir", sa_bus.err_dir, m_err_d);
  endtask

  // One allocator cycle: drive at negedge, check ready, clock, check registers.
  task automatic apply(input logic [19:0] dirs, input logic [199:0] data, input logic [4:0] cin);
    @(negedge sa_clk);
    sa_bus.req_dir_in  = dirs;
    sa_bus.req_data_in = data;
    sa_bus.credit_in   = cin;
    model_eval();
    #1;
    act_ready = sa_bus.rc_ready_out;
    chk("rc_ready", act_ready, m_ready);
    @(posedge sa_clk);
    model_commit();
    #1;
    check_regs();
  endtask

  function automatic logic [19:0] mk_dirs(input logic [3:0] d0, d1, d2, d3, d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [199:0] mk_data(input int tag);
    logic [199:0] d;
    for (int i = 0; i < 5; i++) d[i*40 +: 40] = {4'(i), 4'(tag), 32'(tag * 7 + i + 1)};
    return d;
  endfunction

  function automatic int occ(input int o);
    return int'(sa_bus.occupancy_out[o*4 +: 4]);
  endfunction

  task automatic drain();
    logic [4:0] cin;
    for (int n = 0; n < 9; n++) begin
      cin = '0;
      for (int o = 0; o < 5; o++) cin[o] = m_credit[o] < 8;
      apply({5{DIR_NONE}}, mk_data(n), cin);
    end
  endtask

  typedef struct {
    logic [19:0] dirs;
    logic [4:0]  cin;
    logic [4:0]  exp_ready;
    logic [4:0]  exp_valid;
  } vec_t;

  localparam logic [3:0] NO = DIR_NONE;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    logic [199:0] dref;
    logic [39:0]  flit;
    logic [3:0]   rd   [5];
    logic [39:0]  rdat [5];
    logic [3:0]   codes [5];
    logic [199:0] rbus;
    logic [19:0]  rdirs;
    logic [4:0]   rcin;

    vecs[0] = '{mk_dirs(NO, NO, NO, NO, NO),          5'b0, 5'b11111, 5'b00000};
    vecs[1] = '{mk_dirs(NO, NO, DIR_N, NO, NO),       5'b0, 5'b11111, 5'b01000};
    vecs[2] = '{mk_dirs(DIR_W, DIR_W, NO, NO, DIR_W), 5'b0, 5'b01101, 5'b10000};
    vecs[3] = '{mk_dirs(DIR_W, DIR_W, NO, NO, DIR_W), 5'b0, 5'b01110, 5'b10000};
    vecs[4] = '{mk_dirs(DIR_W, DIR_W, NO, NO, DIR_W), 5'b0, 5'b11100, 5'b10000};
    vecs[5] = '{mk_dirs(DIR_W, DIR_W, NO, NO, DIR_W), 5'b0, 5'b01101, 5'b10000};
    codes = '{DIR_L, DIR_S, DIR_E, DIR_N, DIR_W};

    rst_n              = 1'b0;
    sa_bus.req_dir_in  = {5{DIR_NONE}};
    sa_bus.req_data_in = '0;
    sa_bus.credit_in   = '0;
    model_reset();
    repeat (3) @(posedge sa_clk);
    @(negedge sa_clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", sa_bus.out_valid, 5'b0);
    chk("rst_occ", sa_bus.occupancy_out, 20'b0);
    chk("rst_err_credit", sa_bus.err_credit, 1'b0);
    chk("rst_err_dir", sa_bus.err_dir, 1'b0);
    chk("rst_ready", sa_bus.rc_ready_out, 5'b11111);

    // Table: idle, single flit to N, then W contention rotating 0,1,4,0.
    for (int v = 0; v < 6; v++) begin
      apply(vecs[v].dirs, mk_data(v), vecs[v].cin);
      chk($sformatf("vec%0d_ready", v), act_ready, vecs[v].exp_ready);
      chk($sformatf("vec%0d_valid", v), sa_bus.out_valid, vecs[v].exp_valid);
      if (v == 1) begin
        dref = mk_data(1);
        flit = dref[2*40 +: 40];
        chk("single_data", sa_bus.out_data[3*40 +: 40], flit);
        chk("single_occ", occ(3), 1);
      end
    end

    // Credit stall on E.
    for (int k = 0; k < 8; k++) apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(10 + k), 5'b0);
    chk("stall_occ8", occ(2), 8);
    apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(20), 5'b0);
    chk("stall_ready", act_ready[0], 1'b0);
    chk("stall_valid", sa_bus.out_valid[2], 1'b0);
    apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(20), 5'b00100);
    chk("credit_ret_ready", act_ready[0], 1'b0);
    chk("credit_ret_occ", occ(2), 7);
    apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(20), 5'b0);
    chk("resume_ready", act_ready[0], 1'b1);
    chk("resume_valid", sa_bus.out_valid[2], 1'b1);
    apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(21), 5'b00100);
    apply(mk_dirs(DIR_E, NO, NO, NO, NO), mk_data(21), 5'b00100);
    chk("gnt_and_credit_occ", occ(2), 7);
    chk("gnt_and_credit_ready", act_ready[0], 1'b1);
    drain();

    // Error flags.
    apply({5{DIR_NONE}}, mk_data(30), 5'b00010);
    chk("err_credit_set", sa_bus.err_credit, 1'b1);
    chk("err_credit_occ", occ(1), 0);
    apply(mk_dirs(NO, NO, NO, 4'b0011, NO), mk_data(31), 5'b0);
    chk("err_dir_ready", act_ready[3], 1'b1);
    chk("err_dir_set", sa_bus.err_dir, 1'b1);
    chk("err_dir_novalid", sa_bus.out_valid, 5'b0);

    // Random traffic with RC-style hold on blocked requests.
    for (int i = 0; i < 5; i++) begin
      rd[i]   = DIR_NONE;
      rdat[i] = '0;
    end
    m_ready = '1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 5; i++) begin
        if (m_ready[i]) begin
          int r;
          r = int'($urandom_range(0, 19));
          if (r < 10)       rd[i] = codes[r % 5];
          else if (r == 19) rd[i] = 4'b0110;
          else              rd[i] = DIR_NONE;
          rdat[i] = 40'({$urandom(), $urandom()});
        end
        rdirs[i*4 +: 4]  = rd[i];
        rbus[i*40 +: 40] = rdat[i];
      end
      for (int o = 0; o < 5; o++)
        rcin[o] = (m_credit[o] < 8) ? 1'($urandom_range(0, 1))
                                    : ($urandom_range(0, 49) == 0);
      apply(rdirs, rbus, rcin);
    end
    drain();

    // Reset mid-stream; S pointer moved to 2 beforehand.
    apply(mk_dirs(NO, DIR_S, NO, NO, NO), mk_data(40), 5'b0);
    @(negedge sa_clk);
    sa_bus.req_dir_in  = mk_dirs(DIR_W, NO, DIR_N, NO, DIR_L);
    sa_bus.req_data_in = mk_data(41);
    @(posedge sa_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", sa_bus.out_valid, 5'b0);
    chk("midrst_data", sa_bus.out_data, 200'b0);
    chk("midrst_occ", sa_bus.occupancy_out, 20'b0);
    chk("midrst_errs", {sa_bus.err_credit, sa_bus.err_dir}, 2'b00);
    model_reset();
    sa_bus.req_dir_in = {5{DIR_NONE}};
    @(negedge sa_clk);
    rst_n = 1'b1;
    apply(mk_dirs(NO, DIR_S, NO, DIR_S, NO), mk_data(42), 5'b0);
    chk("postrst_ready", act_ready, 5'b10111);
    dref = mk_data(42);
    flit = dref[1*40 +: 40];
    chk("postrst_data", sa_bus.out_data[1*40 +: 40], flit);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
